// File: rtl/keccak_chi_pini.sv
// Two-share masked Keccak chi layer: one HPC1 AND gadget per output bit, two register stages,
// plus the combinational lane-order <-> S-box-order bit permutations used around it.

module ReOrderChiSquence (
    input  logic [1599:0] orgin,
    output logic [1599:0] reorder
);
    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            for (genvar z = 0; z < 64; z++) begin : g_z
                assign reorder[5*(64*y+z)+x] = orgin[(5*y+x)*64+z];
            end
        end
    end
endmodule

module InvReOrderChiSquence (
    input  logic [1599:0] reorder,
    output logic [1599:0] orgin
);
    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            for (genvar z = 0; z < 64; z++) begin : g_z
                assign orgin[(5*y+x)*64+z] = reorder[5*(64*y+z)+x];
            end
        end
    end
endmodule

module keccak_chi_pini #(
    parameter int SBOX_NUM = 320
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*SBOX_NUM-1:0]   din_0,
    input  logic [5*SBOX_NUM-1:0]   din_1,
    input  logic [10*SBOX_NUM-1:0]  rand_data,
    output logic [5*SBOX_NUM-1:0]   dout_0,
    output logic [5*SBOX_NUM-1:0]   dout_1
);
    localparam int DATA_W = 5 * SBOX_NUM;

    logic [DATA_W-1:0] w_na0_p0, w_na1_p0, w_q0_p0, w_q1_p0, w_r1_p0;

    logic [DATA_W-1:0] r_na0_p1, r_na1_p1, r_q0_p1, r_q1_p1, r_r1_p1;
    logic [DATA_W-1:0] r_a0_p1, r_a1_p1;

    logic [DATA_W-1:0] r_c00_p2, r_c01_p2, r_c10_p2, r_c11_p2;
    logic [DATA_W-1:0] r_a0_p2, r_a1_p2;

    // The NOT of ~a[x+1] lands on share 0 only; r0 refreshes the a[x+2] operand per share.
    for (genvar i = 0; i < SBOX_NUM; i++) begin : g_sbox
        for (genvar x = 0; x < 5; x++) begin : g_bit
            assign w_na0_p0[5*i+x] = ~din_0[5*i+(x+1)%5];
            assign w_na1_p0[5*i+x] =  din_1[5*i+(x+1)%5];
            assign w_q0_p0[5*i+x]  =  din_0[5*i+(x+2)%5] ^ rand_data[10*i+x];
            assign w_q1_p0[5*i+x]  =  din_1[5*i+(x+2)%5] ^ rand_data[10*i+x];
            assign w_r1_p0[5*i+x]  =  rand_data[10*i+5+x];
        end
    end

    // Stage 1: refreshed operands, inverted operand, cross-term mask, linear shares
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_na0_p1 <= '0;
            r_na1_p1 <= '0;
            r_q0_p1  <= '0;
            r_q1_p1  <= '0;
            r_r1_p1  <= '0;
            r_a0_p1  <= '0;
            r_a1_p1  <= '0;
        end else begin
            r_na0_p1 <= w_na0_p0;
            r_na1_p1 <= w_na1_p0;
            r_q0_p1  <= w_q0_p0;
            r_q1_p1  <= w_q1_p0;
            r_r1_p1  <= w_r1_p0;
            r_a0_p1  <= din_0;
            r_a1_p1  <= din_1;
        end
    end

    // Stage 2: domain terms plus r1-masked cross terms; shares only meet here, behind a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c00_p2 <= '0;
            r_c11_p2 <= '0;
            r_c01_p2 <= '0;
            r_c10_p2 <= '0;
            r_a0_p2  <= '0;
            r_a1_p2  <= '0;
        end else begin
            r_c00_p2 <= r_na0_p1 & r_q0_p1;
            r_c11_p2 <= r_na1_p1 & r_q1_p1;
            r_c01_p2 <= (r_na0_p1 & r_q1_p1) ^ r_r1_p1;
            r_c10_p2 <= (r_na1_p1 & r_q0_p1) ^ r_r1_p1;
            r_a0_p2  <= r_a0_p1;
            r_a1_p2  <= r_a1_p1;
        end
    end

    assign dout_0 = r_a0_p2 ^ r_c00_p2 ^ r_c01_p2;
    assign dout_1 = r_a1_p2 ^ r_c11_p2 ^ r_c10_p2;
endmodule

// File: tb/tb_keccak_chi_pini.sv
// Bench for keccak_chi_pini: random shares versus an unmasked lane-order chi model.

module tb_keccak_chi_pini;
    logic          clk;
    logic          rst_n;
    logic [1599:0] din_0, din_1, dout_0, dout_1;
    logic [3199:0] rand_data;
    logic [1599:0] t_org, t_re, t_inv_in, t_inv_out;

    int total = 0;
    int bad   = 0;

    keccak_chi_pini #(.SBOX_NUM(320)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_0     (din_0),
        .din_1     (din_1),
        .rand_data (rand_data),
        .dout_0    (dout_0),
        .dout_1    (dout_1)
    );

    ReOrderChiSquence    u_re  (.orgin(t_org),      .reorder(t_re));
    InvReOrderChiSquence u_inv (.reorder(t_inv_in), .orgin(t_inv_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lidx(input int x, input int y, input int z);
        return (5*y + x)*64 + z;
    endfunction

    function automatic logic [1599:0] ref_reorder(input logic [1599:0] o);
        logic [1599:0] r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < 64; z++)
                    r[5*(64*y+z)+x] = o[lidx(x, y, z)];
        return r;
    endfunction

    function automatic logic [1599:0] ref_chi(input logic [1599:0] a);
        logic [1599:0] b;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < 64; z++)
                    b[lidx(x, y, z)] = a[lidx(x, y, z)]
                        ^ (~a[lidx((x+1)%5, y, z)] & a[lidx((x+2)%5, y, z)]);
        return b;
    endfunction

    function automatic logic [1599:0] rand1600();
        logic [1599:0] v;
        for (int k = 0; k < 50; k++) v[32*k +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [3199:0] rand3200();
        logic [3199:0] v;
        for (int k = 0; k < 100; k++) v[32*k +: 32] = $urandom();
        return v;
    endfunction

    function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
        for (int k = 0; k < 1600; k++) if (a[k] !== b[k]) return k;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: first differing bit %0d, observed[63:0]=%h expected[63:0]=%h",
                   tag, first_diff(obs, exp), obs[63:0], exp[63:0]);
        end
    endtask

    task automatic check_ne(input string tag, input logic [1599:0] obs, input logic [1599:0] other);
        total++;
        assert (obs !== other) else begin
            bad++;
            $error("FAIL %s: observed[63:0]=%h required to differ from %h", tag, obs[63:0], other[63:0]);
        end
    endtask

    logic [1599:0] exp_v, s0, s1, lane_exp;
    logic [1599:0] gs0 [3];
    logic [1599:0] gs1 [3];
    logic [1599:0] d0_zero, d0_ones, d0_rand;
    logic [3199:0] rd_rep;

    initial begin
        rst_n = 1'b0;
        din_0 = '0;
        din_1 = '0;
        rand_data = '0;
        t_org = '0;
        t_inv_in = '0;
        for (int i = 0; i < 320; i++) rd_rep[10*i +: 10] = 10'h3ef;

        // reset state
        #12;
        check("reset_dout_0", dout_0, '0);
        check("reset_dout_1", dout_1, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // single S-box vectors, back to back
        din_0 = '0; din_1 = '0; din_0[4:0] = 5'h0a; din_1[4:0] = 5'h11; rand_data = rd_rep;
        @(negedge clk);
        check("first_out_zero", dout_0 ^ dout_1, '0);
        din_0 = '0; din_1 = '0; din_0[4:0] = 5'h17; din_1[4:0] = 5'h0f;
        @(negedge clk);
        exp_v = '0; exp_v[4:0] = 5'h19;
        check("sbox_vec1", dout_0 ^ dout_1, exp_v);
        din_0 = '0; din_1 = '0;
        @(negedge clk);
        exp_v = '0; exp_v[4:0] = 5'h1a;
        check("sbox_vec2", dout_0 ^ dout_1, exp_v);

        // reorder mapping
        t_org = '0; t_org[451] = 1'b1;
        #1;
        exp_v = '0; exp_v[337] = 1'b1;
        check("reorder_451", t_re, exp_v);
        t_inv_in = exp_v;
        #1;
        exp_v = '0; exp_v[451] = 1'b1;
        check("invreorder_337", t_inv_out, exp_v);
        for (int k = 0; k < 3; k++) begin
            t_org = rand1600();
            #1;
            check("reorder_rand", t_re, ref_reorder(t_org));
            t_inv_in = t_re;
            #1;
            check("roundtrip_rand", t_inv_out, t_org);
        end

        // three back-to-back random states, full pipeline
        for (int k = 0; k < 3; k++) begin
            gs0[k] = rand1600();
            gs1[k] = rand1600();
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                t_inv_in = dout_0 ^ dout_1;
                #1;
                check("golden_state", t_inv_out, ref_chi(gs0[k-2] ^ gs1[k-2]));
            end
            if (k < 3) begin
                din_0 = ref_reorder(gs0[k]);
                din_1 = ref_reorder(gs1[k]);
                rand_data = rand3200();
            end else begin
                din_0 = '0;
                din_1 = '0;
            end
        end

        // randomness independence
        s0 = rand1600();
        s1 = rand1600();
        exp_v = ref_reorder(ref_chi(s0 ^ s1));
        @(negedge clk);
        din_0 = ref_reorder(s0);
        din_1 = ref_reorder(s1);
        rand_data = '0;
        @(negedge clk);
        rand_data = '1;
        @(negedge clk);
        check("rand_zero", dout_0 ^ dout_1, exp_v);
        d0_zero = dout_0;
        rand_data = rand3200();
        @(negedge clk);
        check("rand_ones", dout_0 ^ dout_1, exp_v);
        d0_ones = dout_0;
        @(negedge clk);
        check("rand_random", dout_0 ^ dout_1, exp_v);
        d0_rand = dout_0;
        check_ne("share_ones_differs", d0_ones, d0_zero);
        check_ne("share_rand_differs", d0_rand, d0_zero);

        // asynchronous reset mid-stream
        din_0 = ref_reorder(rand1600());
        din_1 = ref_reorder(rand1600());
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout_0", dout_0, '0);
        check("async_rst_dout_1", dout_1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = rand1600();
        s1 = rand1600();
        lane_exp = ref_chi(s0 ^ s1);
        din_0 = ref_reorder(s0);
        din_1 = ref_reorder(s1);
        rand_data = rand3200();
        @(negedge clk);
        check("post_rst_zero", dout_0 ^ dout_1, '0);
        din_0 = '0;
        din_1 = '0;
        @(negedge clk);
        t_inv_in = dout_0 ^ dout_1;
        #1;
        check("post_rst_result", t_inv_out, lane_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keccak_chi_pini.md
# keccak_chi_pini

Two-share masked Keccak-f[1600] χ layer built from 320 PINI 5-bit S-boxes, with the lane↔S-box bit-order permutations it needs. It sits in the masked keccak-f round between π and ι. Both shares must be in S-box order; `ReOrderChiSquence` converts to that order and `InvReOrderChiSquence` converts back.

## Interface
- `SBOX_NUM`, default 320: number of 5-bit S-boxes. Fixed at 320 for Keccak-f[1600].
- `clk` input 1: single clock. All registers are rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din_0` input 1600: share 0, in S-box order.
- `din_1` input 1600: share 1, in S-box order.
- `rand_data` input 3200: fresh randomness, 10 bits per S-box. Must be uniform and new every cycle.
- `dout_0` output 1600: share 0 of χ(din_0 ^ din_1), in S-box order.
- `dout_1` output 1600: share 1 of the same result, in S-box order.
- Helper `ReOrderChiSquence`: input `orgin` 1600, output `reorder` 1600. Purely combinational.
- Helper `InvReOrderChiSquence`: input `reorder` 1600, output `orgin` 1600. Purely combinational.

## Operation
- **Lane order.** Bit z of lane (x,y) is at index (5y+x)·64+z, with x,y in 0..4 and z in 0..63.
- **S-box order.** S-box i = 64y+z. Its bit x is at index 5i+x.
  - `reorder[5(64y+z)+x] = orgin[(5y+x)·64+z]`.
  - `InvReOrderChiSquence` is the exact inverse, so Inv(ReOrder(s)) = s.
- **Per S-box i.** Input shares are a0[x] = din_0[5i+x] and a1[x] = din_1[5i+x]. Indices x+1 and x+2 wrap mod 5.
- **Target function.** The unmasked result is b[x] = a[x] ^ (~a[x+1] & a[x+2]).
- **Each AND term is one HPC1 gadget** (refresh followed by DOM-independent multiply).
  - Randomness: r0 = rand_data[10i+x], r1 = rand_data[10i+5+x].
  - NOT input: na0 = ~a0[x+1], na1 = a1[x+1]. The NOT is applied on share 0 only.
- **Stage 1 registers:**
  - Refreshed operand: q0 = a0[x+2]^r0 and q1 = a1[x+2]^r0.
  - na0, na1, and r1.
  - Linear shares a0[x] and a1[x].
- **Stage 2 registers:**
  - Domain terms: c00 = na0&q0 and c11 = na1&q1.
  - Cross terms: c01 = (na0&q1)^r1 and c10 = (na1&q0)^r1.
  - Linear shares delayed one more cycle.
- **Output (combinational XOR of stage-2 registers only):**
  - dout_0[5i+x] = a0d ^ c00 ^ c01.
  - dout_1[5i+x] = a1d ^ c11 ^ c10.
- **Security rules:**
  - Share-0 and share-1 logic mix only through registered cross terms masked by r1.
  - No share recombination is allowed before the stage-2 registers.
- **Correctness:** dout_0 ^ dout_1 = χ(din_0 ^ din_1), independent of rand_data.

## Timing
- **Latency:** 2 cycles. Inputs and rand_data are sampled together at edge k; the result is valid after edge k+2.
- **Throughput:** fully pipelined, one new state per cycle. There is no handshake or valid signal.
- **Reset:** rst_n low asynchronously clears every register. dout_0 and dout_1 read all-zero while reset is held.
- **After reset release:** the first valid output appears 2 edges after the first sampled input. Outputs before that are 0^0 terms, i.e. zero.
- **Reset mid-operation:** in-flight data is discarded. There is no partial output.
- **Helpers:** zero latency, no state.

## Test plan
- **Single S-box, first vector.** S-box 0 rows din_0 = 5'h0a, din_1 = 5'h11 (unmasked 5'h1b); all other bits 0; rand_data = 10'h3ef repeated. Two cycles later, dout_0^dout_1 bits [4:0] = 5'h19 and all other bits 0.
- **Single S-box, second vector.** din_0 = 5'h17, din_1 = 5'h0f (unmasked 5'h18). Result bits [4:0] = 5'h1a.
- **Reorder mapping.** orgin has only bit 451 set (x=2, y=1, z=3). reorder has only bit 337 set. The inverse maps 337 back to 451. Random 1600-bit states round-trip unchanged.
- **Full state against a golden model.** Random shares pass through ReOrder → DUT → XOR → InvReOrder. Compare against the unmasked χ in lane order for 3 back-to-back vectors presented on consecutive cycles; each result must arrive exactly 2 cycles after its input.
- **Randomness independence.** Hold the same shares and apply rand_data = 0, then all-ones, then random. The unmasked output is identical in all three cases. The individual shares differ when rand_data is nonzero.
- **Reset.** Assert rst_n low mid-stream: outputs go to 0 immediately, without waiting for a clock edge. After release, the first input gives a correct result 2 cycles later.
